// File: rtl/cmd_pkg.sv
// Shared command codes and FSM state encoding for the button command path.
// Codes are active-low one-cold patterns matching the raw button wiring.
package cmd_pkg;

    localparam logic [2:0] CMD_IDLE = 3'b111;
    localparam logic [2:0] CMD_LOAD = 3'b110;
    localparam logic [2:0] CMD_ADD1 = 3'b101;
    localparam logic [2:0] CMD_FIB  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_HELD = 2'd2
    } state_t;

    // A press is a command only when exactly one button is down.
    function automatic logic is_single_press(input logic [2:0] v);
        return (v == CMD_LOAD) || (v == CMD_ADD1) || (v == CMD_FIB);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Vector-wide 2-FF synchronizer plus a shared debounce counter.
// The debounced vector only follows a level held for DEBOUNCE_CYCLES samples.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_btn_n,
    output logic [2:0] o_deb
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_deb;
    logic [CNT_W-1:0] r_cnt;
    logic             w_stable;

    // The two synchronizer taps are consecutive samples: equal means no change.
    assign w_stable = (r_sync1 == r_sync2) && (r_sync2 != r_deb);
    assign o_deb    = r_deb;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 3'b111;
            r_sync2 <= 3'b111;
            r_deb   <= 3'b111;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            if (!w_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == LP_LAST) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_cmd_encoder.sv
// Turns debounced active-low buttons into one-cycle command pulses,
// dropping (and counting) presses that arrive while the controller is busy.
module button_cmd_encoder
    import cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btn_n,
    input  logic       busy,
    output logic [2:0] button_code,
    output logic       cmd_valid,
    output logic [7:0] drop_count
);

    logic [2:0] w_deb;
    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_code;
    logic [2:0] w_code_nxt;
    logic       r_vld;
    logic       w_vld_nxt;
    logic [7:0] r_drop;
    logic [7:0] w_drop_nxt;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_btn_n (btn_n),
        .o_deb   (w_deb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_code  <= CMD_IDLE;
            r_vld   <= 1'b0;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_vld   <= w_vld_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    // The pulse is registered on the IDLE->EMIT edge, so it is visible during EMIT.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = CMD_IDLE;
        w_vld_nxt   = 1'b0;
        w_drop_nxt  = r_drop;
        case (r_state)
            ST_IDLE: begin
                if (w_deb != CMD_IDLE) begin
                    w_state_nxt = ST_HELD;
                    if (is_single_press(w_deb)) begin
                        if (!busy) begin
                            w_state_nxt = ST_EMIT;
                            w_code_nxt  = w_deb;
                            w_vld_nxt   = 1'b1;
                        end else if (r_drop != 8'hFF) begin
                            w_drop_nxt = r_drop + 8'd1;
                        end
                    end
                end
            end
            ST_EMIT: w_state_nxt = ST_HELD;
            ST_HELD: begin
                if (w_deb == CMD_IDLE) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign button_code = r_code;
    assign cmd_valid   = r_vld;
    assign drop_count  = r_drop;

endmodule
